// File: rtl/operand_fetch_sequencer_if.sv
// operand_fetch_sequencer_if: decode/bus signals between the core and the operand fetch sequencer
// slave  : sequencer side (takes start/operand_count/pc_in/rdy/db_in, drives addr/latch/pc/status/operand)
// master : decode/bus side (mirror of slave)
interface operand_fetch_sequencer_if;
  logic        start;
  logic [1:0]  operand_count;
  logic [15:0] pc_in;
  logic        rdy;
  logic [7:0]  db_in;
  logic [15:0] addr_out;
  logic        rwb;
  logic        latch_clear;
  logic        latch_strobe;
  logic        pc_inc;
  logic        busy;
  logic        done;
  logic [15:0] operand_out;
  logic        error;
  modport slave (
    input  start, operand_count, pc_in, rdy, db_in,
    output addr_out, rwb, latch_clear, latch_strobe, pc_inc, busy, done, operand_out, error
  );
  modport master (
    output start, operand_count, pc_in, rdy, db_in,
    input  addr_out, rwb, latch_clear, latch_strobe, pc_inc, busy, done, operand_out, error
  );
endinterface

// File: rtl/operand_fetch_sequencer.sv
// operand_fetch_sequencer: fetches 0-2 operand bytes after the opcode, driving latch clear/strobe, read address and pc_inc
// fclk/reset : core clock, synchronous active-high reset
// bus        : operand_fetch_sequencer_if.slave (request, RDY, data bus in; address, latch strobes, status, operand out)
// OPFETCH_TIMEOUT_EN : when defined, a RDY stall of TIMEOUT_CYCLES aborts the fetch and sets a sticky error
module operand_fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic                       fclk,
  input logic                       reset,
  operand_fetch_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [15:0] operand_q, operand_d;
  logic [1:0]  count_q, count_d;
  logic        clr_q;
  logic        accept, fetch, take, abort;
  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W cannot hold TIMEOUT_CYCLES");
  end
  assign accept = !reset && state_q == IDLE && bus.start;
  assign fetch  = state_q == FETCH_LO || state_q == FETCH_HI;
  // gated by reset so a reset landing mid-fetch never strobes the latch
  assign take   = !reset && fetch && bus.rdy;
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    operand_d = operand_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        base_d    = bus.pc_in;
        count_d   = bus.operand_count == 2'd3 ? 2'd2 : bus.operand_count;
        operand_d = '0;
        state_d   = bus.operand_count == 2'd0 ? DONE : FETCH_LO;
      end
      FETCH_LO: if (bus.rdy) begin
        operand_d[7:0] = bus.db_in;
        state_d        = count_q == 2'd2 ? FETCH_HI : DONE;
      end
      FETCH_HI: if (bus.rdy) begin
        operand_d[15:8] = bus.db_in;
        state_d         = DONE;
      end
      DONE: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      count_q   <= '0;
      operand_q <= '0;
      clr_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      operand_q <= operand_d;
      clr_q     <= 1'b0;
    end
  end
`ifdef OPFETCH_TIMEOUT_EN
  logic [CNT_W-1:0] wait_q;
  logic             err_q;
  // abort on the TIMEOUT_CYCLES-th consecutive stalled cycle
  assign abort = fetch && !bus.rdy && wait_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge fclk) begin
    if (reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= (fetch && !bus.rdy && !abort) ? wait_q + CNT_W'(1) : '0;
      err_q  <= abort ? 1'b1 : accept ? 1'b0 : err_q;
    end
  end
  assign bus.error = err_q;
`else
  assign abort     = 1'b0;
  assign bus.error = 1'b0;
`endif
  assign bus.addr_out     = state_q == FETCH_HI ? base_q + 16'd1 : base_q;
  assign bus.rwb          = 1'b1;
  assign bus.latch_clear  = !reset && (clr_q || accept || abort);
  assign bus.latch_strobe = take;
  assign bus.pc_inc       = take;
  assign bus.busy         = state_q != IDLE;
  assign bus.done         = state_q == DONE;
  assign bus.operand_out  = operand_q;
endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// tb_operand_fetch_sequencer: scoreboard bench for operand_fetch_sequencer
module tb_operand_fetch_sequencer;
  logic fclk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  typedef struct {
    logic [15:0] op;
    int          at;
  } done_t;
  logic [15:0] strb_q[$];
  done_t       done_q[$];
  logic [7:0]  mem [0:65535];
  operand_fetch_sequencer_if bus();
`ifdef OPFETCH_TIMEOUT_EN
  operand_fetch_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (.fclk(fclk), .reset(reset), .bus(bus));
`else
  operand_fetch_sequencer dut (.fclk(fclk), .reset(reset), .bus(bus));
`endif
  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;
  assign bus.db_in = mem[bus.addr_out];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic step();
    @(posedge fclk);
    #1;
  endtask
  task automatic issue(input logic [1:0] n, input logic [15:0] pc, input logic [15:0] op, input int lat);
    done_t d;
    bus.start         = 1'b1;
    bus.operand_count = n;
    bus.pc_in         = pc;
    if (n >= 2'd1) strb_q.push_back(pc);
    if (n >= 2'd2) strb_q.push_back(pc + 16'd1);
    d.op = op;
    d.at = cyc + lat;
    done_q.push_back(d);
    step();
    bus.start = 1'b0;
  endtask
  always @(negedge fclk) begin
    if (!reset) begin
      if (bus.start && !bus.busy) check("clr_at_accept", 32'(bus.latch_clear), 1);
      if (bus.latch_strobe || bus.pc_inc) begin
        if (strb_q.size() == 0) check("strobe_expected", 32'(strb_q.size() != 0), 1);
        else begin
          logic [15:0] a;
          a = strb_q.pop_front();
          check("strobe_addr", 32'(bus.addr_out), 32'(a));
          check("strobe_pc_inc", {30'd0, bus.latch_strobe, bus.pc_inc}, 3);
          check("strobe_no_clear_rwb", {30'd0, bus.latch_clear, bus.rwb}, 1);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) check("done_expected", 32'(done_q.size() != 0), 1);
        else begin
          done_t d;
          d = done_q.pop_front();
          check("done_operand", 32'(bus.operand_out), 32'(d.op));
          check("done_cycle", cyc, d.at);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    mem[16'h2000] = 8'h42; mem[16'h2001] = 8'h99;
    mem[16'h8000] = 8'h77; mem[16'h8001] = 8'h66;
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    mem[16'h3000] = 8'h01; mem[16'h3001] = 8'h02;
    mem[16'h5000] = 8'h55; mem[16'h5001] = 8'h5A;
    reset = 1'b1;
    bus.start = 1'b0; bus.operand_count = 2'd0; bus.pc_in = 16'h0; bus.rdy = 1'b1;
    step(); step();
    @(negedge fclk);
    check("rst_busy_done", {30'd0, bus.busy, bus.done}, 0);
    check("rst_addr", 32'(bus.addr_out), 0);
    check("rst_operand", 32'(bus.operand_out), 0);
    check("rst_strobe_pcinc_err", {29'd0, bus.latch_strobe, bus.pc_inc, bus.error}, 0);
    check("rst_rwb", 32'(bus.rwb), 1);
    step(); reset = 1'b0;
    @(negedge fclk);
    check("post_rst_clear", 32'(bus.latch_clear), 1);
    step();
    @(negedge fclk);
    check("post_rst_clear_off", 32'(bus.latch_clear), 0);
    step();
    issue(2'd2, 16'h1234, 16'hABCD, 3);
    repeat (4) step();
    issue(2'd1, 16'h2000, 16'h0042, 2);
    repeat (3) step();
    issue(2'd0, 16'h7000, 16'h0000, 1);
    repeat (2) step();
    issue(2'd3, 16'h8000, 16'h6677, 3);
    repeat (4) step();
    issue(2'd2, 16'hFFFF, 16'h2211, 6);
    step(); bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge fclk);
      check("stall_addr_wrap", 32'(bus.addr_out), 0);
      check("stall_no_strobe", {30'd0, bus.latch_strobe, bus.pc_inc}, 0);
      step();
    end
    bus.rdy = 1'b1;
    repeat (3) step();
    issue(2'd2, 16'h3000, 16'h0201, 3);
    bus.start = 1'b1; bus.operand_count = 2'd1; bus.pc_in = 16'h4000;
    step(); bus.start = 1'b0;
    step(); bus.start = 1'b1;
    step(); bus.start = 1'b0;
    repeat (2) step();
    bus.start = 1'b1; bus.operand_count = 2'd2; bus.pc_in = 16'h5000;
    strb_q.push_back(16'h5000);
    step(); bus.start = 1'b0;
    step(); reset = 1'b1;
    @(negedge fclk);
    check("rst_cycle_no_strobe", {30'd0, bus.latch_strobe, bus.pc_inc}, 0);
    step(); reset = 1'b0;
    @(negedge fclk);
    check("midrst_idle", {30'd0, bus.busy, bus.latch_strobe}, 0);
    check("midrst_clear", 32'(bus.latch_clear), 1);
    step();
    @(negedge fclk);
    check("midrst_clear_off", 32'(bus.latch_clear), 0);
    step();
`ifdef OPFETCH_TIMEOUT_EN
    bus.start = 1'b1; bus.operand_count = 2'd1; bus.pc_in = 16'h6000;
    step(); bus.start = 1'b0; bus.rdy = 1'b0;
    repeat (3) step();
    @(negedge fclk);
    check("to_clear", {30'd0, bus.latch_clear, bus.error}, 2);
    step(); bus.rdy = 1'b1;
    @(negedge fclk);
    check("to_error_idle", {30'd0, bus.error, bus.busy}, 2);
    step();
    issue(2'd0, 16'h7000, 16'h0000, 1);
    @(negedge fclk);
    check("to_error_cleared", 32'(bus.error), 0);
    step();
`endif
    for (int i = 0; i < 20 && (strb_q.size() != 0 || done_q.size() != 0); i++) step();
    check("strobes_drained", strb_q.size(), 0);
    check("dones_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
